uart_tx_arbiter: RTL and testbench

Shares one `uart_tx` transmitter between two byte sources, A and B. Each source has its own small FIFO. The block sits between the `uart_rx` outputs (or any valid/data byte producer) and a single `uart_tx` `en`/`data_in`/`rdy` port. It replaces the combinational valid-mux in front of the bridge transmitters, so bytes from both sources are serialised without loss or double-issue.

---
 rtl/uart_tx_arbiter_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_fifo.sv | 71 +++++++
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-source UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int DATA_W = 8;
  localparam int DROP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_RDY  = 2'd3
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_fifo.sv
// Small show-ahead byte FIFO: head byte is always visible on dout, level
// counter provides full/empty, flush clears pointers and level.
module byte_fifo
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] dout,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push;
  logic              do_pop;

  // Fullness is taken from the registered level, i.e. before any same-cycle pop.
  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointer and level next-state; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between byte sources A and B: per-source FIFOs,
// strict-priority or round-robin grant, and an issue/handshake FSM that
// guarantees each byte is presented exactly once.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int DEPTH        = 4,
  parameter  int GUARD_CYCLES = 2,
  localparam int LVL_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              prio_b,
  input  logic              flush,
  input  logic              tx_rdy,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_src,
  output logic [LVL_W-1:0]  a_level,
  output logic [LVL_W-1:0]  b_level,
  output logic [DROP_W-1:0] a_drops,
  output logic [DROP_W-1:0] b_drops
);

  localparam int GC_W = $clog2(GUARD_CYCLES + 1);

  state_e            state_q, state_d;
  logic [GC_W-1:0]   guard_q, guard_d;
  logic              tx_en_q, tx_en_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  src_e              tx_src_q, tx_src_d;
  src_e              last_q, last_d;
  logic [DROP_W-1:0] a_drops_q, a_drops_d;
  logic [DROP_W-1:0] b_drops_q, b_drops_d;

  logic [DATA_W-1:0] a_head, b_head;
  logic              a_full, a_empty, b_full, b_empty;
  logic              pop_a, pop_b;
  logic              grant_b;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (a_valid),
    .din   (a_data),
    .pop   (pop_a),
    .flush (flush),
    .dout  (a_head),
    .level (a_level),
    .full  (a_full),
    .empty (a_empty)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (b_valid),
    .din   (b_data),
    .pop   (pop_b),
    .flush (flush),
    .dout  (b_head),
    .level (b_level),
    .full  (b_full),
    .empty (b_empty)
  );

  // Pick the winner assuming at least one FIFO holds data: a lone source wins,
  // otherwise prio_b forces B, else the source that did not win last time.
  always_comb begin
    grant_b = 1'b0;
    if (a_empty)           grant_b = 1'b1;
    else if (b_empty)      grant_b = 1'b0;
    else if (prio_b)       grant_b = 1'b1;
    else                   grant_b = (last_q == SRC_A);
  end

  // Drop counters only see pushes refused for fullness; flushed pushes are not drops.
  always_comb begin
    a_drops_d = a_drops_q;
    b_drops_d = b_drops_q;
    if (a_valid && a_full && !flush) a_drops_d = sat_inc(a_drops_q);
    if (b_valid && b_full && !flush) b_drops_d = sat_inc(b_drops_q);
  end

  // Issue FSM: grant and pop in IDLE, strobe in ISSUE, then wait for uart_tx
  // to go busy (or the guard to expire) and come back ready.
  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    tx_src_d  = tx_src_q;
    last_d    = last_q;
    pop_a     = 1'b0;
    pop_b     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_rdy && !flush && (!a_empty || !b_empty)) begin
          pop_a     = !grant_b;
          pop_b     = grant_b;
          tx_data_d = grant_b ? b_head : a_head;
          tx_src_d  = grant_b ? SRC_B : SRC_A;
          last_d    = grant_b ? SRC_B : SRC_A;
          tx_en_d   = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        guard_d = GC_W'(GUARD_CYCLES);
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!tx_rdy) begin
          state_d = ST_WAIT_RDY;
        end else if (guard_q <= GC_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q - GC_W'(1);
        end
      end
      ST_WAIT_RDY: begin
        if (tx_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; last grant resets to B so A wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      guard_q   <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      tx_src_q  <= SRC_A;
      last_q    <= SRC_B;
      a_drops_q <= '0;
      b_drops_q <= '0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      tx_src_q  <= tx_src_d;
      last_q    <= last_d;
      a_drops_q <= a_drops_d;
      b_drops_q <= b_drops_d;
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;
  assign tx_src  = tx_src_q;
  assign a_drops = a_drops_q;
  assign b_drops = b_drops_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transaction-level reference model
// (byte queues, arbitration rule, handshake timing) checked every cycle.
module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int G     = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0, prio_b = 1'b0, flush = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       tx_rdy;
  logic       tx_en, tx_src;
  logic [7:0] tx_data;
  logic [2:0] a_level, b_level;
  logic [7:0] a_drops, b_drops;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DEPTH(DEPTH), .GUARD_CYCLES(G)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_data  (b_data),
    .prio_b  (prio_b),
    .flush   (flush),
    .tx_rdy  (tx_rdy),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .tx_src  (tx_src),
    .a_level (a_level),
    .b_level (b_level),
    .a_drops (a_drops),
    .b_drops (b_drops)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- uart_tx stand-in ----------------
  int busy_len = 0;
  int busy_cnt = 0;
  bit hold_low = 1'b0;
  assign tx_rdy = !hold_low && (busy_cnt == 0);

  always @(negedge clk) begin
    if (!rst)                          busy_cnt = 0;
    else if (busy_cnt > 0)             busy_cnt = busy_cnt - 1;
    else if (tx_en && busy_len > 0)    busy_cnt = busy_len;
  end

  // ---------------- reference model ----------------
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         m_last = 1'b1;
  bit         m_en = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_src = 1'b0;
  int         m_adrop = 0, m_bdrop = 0;
  bit         busy = 1'b0, in_issue = 1'b0, fell = 1'b0;
  int         guard_left = 0;
  int         na, nb;
  bit         take_b;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      qa.delete(); qb.delete();
      m_last = 1'b1; m_en = 1'b0; m_data = 8'h00; m_src = 1'b0;
      m_adrop = 0; m_bdrop = 0;
      busy = 1'b0; in_issue = 1'b0; fell = 1'b0; guard_left = 0;
    end else begin
      na = qa.size();
      nb = qb.size();
      m_en = 1'b0;
      if (busy && in_issue) begin
        // strobe cycle just ended; the acceptance window starts
        in_issue = 1'b0; guard_left = G; fell = 1'b0;
      end else if (busy && !fell) begin
        if (!tx_rdy) fell = 1'b1;
        else begin
          guard_left = guard_left - 1;
          if (guard_left == 0) busy = 1'b0;
        end
      end else if (busy) begin
        if (tx_rdy) busy = 1'b0;
      end else if (tx_rdy && !flush && (na + nb) > 0) begin
        if (na == 0)      take_b = 1'b1;
        else if (nb == 0) take_b = 1'b0;
        else if (prio_b)  take_b = 1'b1;
        else              take_b = !m_last;
        m_data = take_b ? qb.pop_front() : qa.pop_front();
        m_src = take_b; m_last = take_b; m_en = 1'b1;
        busy = 1'b1; in_issue = 1'b1;
      end
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (a_valid) begin
          if (na == DEPTH) m_adrop = (m_adrop == 255) ? 255 : m_adrop + 1;
          else qa.push_back(a_data);
        end
        if (b_valid) begin
          if (nb == DEPTH) m_bdrop = (m_bdrop == 255) ? 255 : m_bdrop + 1;
          else qb.push_back(b_data);
        end
      end
    end
  end

  // ---------------- per-cycle compare + issue log ----------------
  int log_q[$];
  int log_cyc[$];

  always @(negedge clk) begin
    if (rst) begin
      check("tx_en",   32'(tx_en),   32'(m_en));
      check("tx_data", 32'(tx_data), 32'(m_data));
      check("tx_src",  32'(tx_src),  32'(m_src));
      check("a_level", 32'(a_level), 32'(qa.size()));
      check("b_level", 32'(b_level), 32'(qb.size()));
      check("a_drops", 32'(a_drops), 32'(m_adrop));
      check("b_drops", 32'(b_drops), 32'(m_bdrop));
      if (tx_en === 1'b1) begin
        log_q.push_back(int'({tx_src, tx_data}));
        log_cyc.push_back(cyc);
        $display("issue cycle=%0d src=%0d data=0x%02h", cyc, tx_src, tx_data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int exp_q[$];

  task automatic drive(input bit av, input logic [7:0] ad, input bit bv, input logic [7:0] bd);
    @(negedge clk);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
  endtask

  task automatic idle_for(input int n);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    log_q.delete(); log_cyc.delete();
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  int t0;

  initial begin
    // Reset then single byte from A
    busy_len = 10;
    do_reset();
    check("rst_tx_en",   32'(tx_en),   32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_src",  32'(tx_src),  32'd0);
    check("rst_a_level", 32'(a_level), 32'd0);
    check("rst_b_drops", 32'(b_drops), 32'd0);
    drive(1, 8'h41, 0, 8'h00);
    t0 = cyc;
    idle_for(25);
    exp_q = '{32'h041};
    check_log("single");
    if (log_cyc.size() > 0) check("single_latency", 32'(log_cyc[0] - t0), 32'd2);

    // Round-robin, A wins first tie after reset
    do_reset();
    busy_len = 3; prio_b = 1'b0;
    drive(1, 8'h10, 1, 8'h20);
    drive(1, 8'h11, 1, 8'h21);
    idle_for(40);
    exp_q = '{32'h010, 32'h120, 32'h011, 32'h121};
    check_log("rr");

    // Strict priority for B
    do_reset();
    prio_b = 1'b1;
    drive(1, 8'h10, 1, 8'h20);
    drive(1, 8'h11, 1, 8'h21);
    idle_for(40);
    exp_q = '{32'h120, 32'h121, 32'h010, 32'h011};
    check_log("prio");
    prio_b = 1'b0;

    // Overflow with transmitter held busy
    do_reset();
    hold_low = 1'b1;
    for (int i = 0; i < 6; i++) drive(1, 8'(8'h30 + i), 0, 8'h00);
    idle_for(3);
    check("ovf_a_level", 32'(a_level), 32'd4);
    check("ovf_a_drops", 32'(a_drops), 32'd2);
    hold_low = 1'b0;
    idle_for(30);
    exp_q = '{32'h030, 32'h031, 32'h032, 32'h033};
    check_log("ovf");

    // Guard expiry: ready never drops
    do_reset();
    busy_len = 0;
    drive(1, 8'h50, 0, 8'h00);
    drive(1, 8'h51, 0, 8'h00);
    drive(1, 8'h52, 0, 8'h00);
    idle_for(25);
    exp_q = '{32'h050, 32'h051, 32'h052};
    check_log("guard");
    for (int i = 1; i < log_cyc.size(); i++)
      check($sformatf("guard_gap%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'(G + 2));

    // Flush with one byte in flight; push during flush is discarded
    do_reset();
    busy_len = 10;
    drive(0, 8'h00, 1, 8'h60);
    drive(0, 8'h00, 1, 8'h61);
    drive(0, 8'h00, 1, 8'h62);
    drive(0, 8'h00, 0, 8'h00);
    check("pre_flush_b_level", 32'(b_level), 32'd2);
    drive(0, 8'h00, 1, 8'h63);
    flush = 1'b1;
    idle_for(25);
    check("flush_b_level", 32'(b_level), 32'd0);
    check("flush_b_drops", 32'(b_drops), 32'd0);
    exp_q = '{32'h160};
    check_log("flush");

    // Asynchronous reset in the middle of WAIT_RDY
    log_q.delete(); log_cyc.delete();
    drive(0, 8'h00, 1, 8'h70);
    drive(1, 8'h71, 0, 8'h00);
    drive(1, 8'h72, 0, 8'h00);
    idle_for(3);
    check("mid_tx_src",  32'(tx_src),  32'd1);
    check("mid_tx_data", 32'(tx_data), 32'h70);
    check("mid_a_level", 32'(a_level), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_tx_en",   32'(tx_en),   32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    check("arst_tx_src",  32'(tx_src),  32'd0);
    check("arst_a_level", 32'(a_level), 32'd0);
    check("arst_b_level", 32'(b_level), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    idle_for(15);
    exp_q = '{32'h170};
    check_log("arst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
